// File: rtl/sync_packet_pkg.sv
// Shared constants, SPI edge bundle and frame-match helper for the sync packet receiver.
package sync_packet_pkg;

  localparam int FRAME_LEN = 63;

  localparam int SYNC0_HI = 62;
  localparam int SYNC0_LO = 58;
  localparam int SYNC1_HI = 36;
  localparam int SYNC1_LO = 32;
  localparam int SYNC2_HI = 8;
  localparam int SYNC2_LO = 0;

  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 8;
  localparam int BUF_W     = BYTE_W * NUM_BYTES;
  localparam int PTR_W     = $clog2(NUM_BYTES);
  localparam int BIT_CNT_W = 4;

  localparam logic [BIT_CNT_W-1:0] BITS_FULL = BIT_CNT_W'(BYTE_W);

  localparam logic [BYTE_W-1:0] RST_PTR_CMD_DEF     = 8'h5A;
  localparam int                SCK_SYNC_STAGES_DEF = 2;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic cs_fall;
    logic cs_rise;
    logic sck_rise;
    logic sck_fall;
  } spi_edges_t;

  // Payload bits between the sync fields are ignored.
  function automatic logic frame_match(input logic [FRAME_LEN-1:0] f);
    return (&f[SYNC0_HI:SYNC0_LO]) & (&f[SYNC1_HI:SYNC1_LO]) & (&f[SYNC2_HI:SYNC2_LO]);
  endfunction

endpackage

// File: rtl/sync_packet_spi_top_spi_slave_byte.sv
// SPI mode-0 slave byte engine: input synchronizers, edge detection, bit counter,
// tx/rx shifters and an end-of-byte pulse on CS release after a full byte.
module spi_slave_byte
  import sync_packet_pkg::*;
#(
  parameter int SYNC_STAGES = SCK_SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic              miso,
  output logic              byte_done,
  output logic [BYTE_W-1:0] rx_byte
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_d;
  logic                   sck_d;
  logic                   cs_s;
  logic                   sck_s;
  logic                   mosi_s;
  spi_edges_t             edges;

  logic [BYTE_W-1:0]    tx_sh;
  logic [BYTE_W-1:0]    rx_sh;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // Synchronizers idle at CS high / SCK low so release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sck_d     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_comb begin
    edges          = '0;
    edges.cs_fall  = cs_d & ~cs_s;
    edges.cs_rise  = ~cs_d & cs_s;
    edges.sck_rise = ~sck_d & sck_s & ~cs_s;
    edges.sck_fall = sck_d & ~sck_s & ~cs_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else if (edges.cs_fall) begin
      tx_sh   <= tx_byte;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else begin
      if (edges.sck_rise) begin
        rx_sh <= {rx_sh[BYTE_W-2:0], mosi_s};
        if (bit_cnt != '1)
          bit_cnt <= bit_cnt + 1'b1;
      end
      // The first bit is presented from CS fall, so only seven shifts are needed.
      if (edges.sck_fall && (bit_cnt != '0) && (bit_cnt < BITS_FULL))
        tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
    end
  end

  assign miso      = cs_s ? 1'b0 : tx_sh[BYTE_W-1];
  assign byte_done = edges.cs_rise & (bit_cnt >= BITS_FULL);
  assign rx_byte   = rx_sh;

endmodule

// File: rtl/sync_packet_spi_top.sv
// Bit-serial frame receiver with sync-field match, frame snapshot and SPI byte read-out.
// Optional build macro PKT_REC_STICKY_EN: pkt_rec holds until all snapshot bytes are read.
module sync_packet_spi_top #(
  parameter int          FRAME_LEN       = sync_packet_pkg::FRAME_LEN,
  parameter int          SCK_SYNC_STAGES = sync_packet_pkg::SCK_SYNC_STAGES_DEF,
  parameter logic [7:0]  RST_PTR_CMD     = sync_packet_pkg::RST_PTR_CMD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic sh_en,
  input  logic CS,
  input  logic SCK,
  input  logic MOSI,
  output logic MISO,
  output logic pkt_rec
);

  import sync_packet_pkg::*;

  logic [FRAME_LEN-1:0] frame;
  logic                 match_c;
  logic                 match_q;
  logic                 snap;
  logic [BUF_W-1:0]     tx_buf;
  ptr_t                 ptr;
  logic [BYTE_W-1:0]    tx_byte;
  logic [BYTE_W-1:0]    rx_byte;
  logic                 byte_done;
  logic                 rewind;
  logic                 ptr_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame <= '0;
    else if (sh_en)
      frame <= {frame[FRAME_LEN-2:0], din};
  end

  assign match_c = frame_match(frame);
  assign snap    = match_c & ~match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      match_q <= 1'b0;
    else
      match_q <= match_c;
  end

  assign rewind   = (rx_byte == RST_PTR_CMD);
  assign ptr_wrap = byte_done & ~snap & ~rewind & (ptr == PTR_W'(NUM_BYTES - 1));

  // A fresh snapshot takes priority over a byte completing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf <= '0;
      ptr    <= '0;
    end else if (snap) begin
      tx_buf <= {frame, 1'b0};
      ptr    <= '0;
    end else if (byte_done) begin
      ptr <= rewind ? '0 : ptr + 1'b1;
    end
  end

  always_comb begin
    tx_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++)
      if (ptr == PTR_W'(i))
        tx_byte = tx_buf[(NUM_BYTES-1-i)*BYTE_W +: BYTE_W];
  end

  spi_slave_byte #(
    .SYNC_STAGES(SCK_SYNC_STAGES)
  ) u_spi (
    .clk      (clk),
    .rst      (rst),
    .cs       (CS),
    .sck      (SCK),
    .mosi     (MOSI),
    .tx_byte  (tx_byte),
    .miso     (MISO),
    .byte_done(byte_done),
    .rx_byte  (rx_byte)
  );

`ifdef PKT_REC_STICKY_EN
  logic pkt_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pkt_sticky <= 1'b0;
    else if (match_c)
      pkt_sticky <= 1'b1;
    else if (ptr_wrap)
      pkt_sticky <= 1'b0;
  end

  assign pkt_rec = pkt_sticky;
`else
  logic unused_wrap;
  assign unused_wrap = ptr_wrap;
  assign pkt_rec     = match_q;
`endif

endmodule

// File: tb/tb_sync_packet_spi_top.sv
// Self-checking bench for sync_packet_spi_top: behavioural frame/snapshot model,
// per-cycle pkt_rec comparison, SPI master task with byte-level checks.
module tb_sync_packet_spi_top;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic din   = 1'b0;
  logic sh_en = 1'b0;
  logic CS    = 1'b1;
  logic SCK   = 1'b0;
  logic MOSI  = 1'b0;
  logic MISO;
  logic pkt_rec;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;

  sync_packet_spi_top dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .sh_en  (sh_en),
    .CS     (CS),
    .SCK    (SCK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .pkt_rec(pkt_rec)
  );

  always #5 clk = ~clk;

  function automatic logic spec_match(input logic [62:0] f);
    return (f[62:58] == 5'b11111) && (f[36:32] == 5'b11111) && (f[8:0] == 9'h1FF);
  endfunction

  // Reference model: frame history, snapshot on rising match, expected pkt_rec.
  logic [62:0] mframe   = '0;
  logic        m_lvl    = 1'b0;
  logic        exp_pkt  = 1'b0;
  logic [63:0] msnap    = '0;
  int          snap_cnt = 0;
`ifdef PKT_REC_STICKY_EN
  int          wrap_req  = 0;
  int          wrap_seen = 0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mframe  <= '0;
      m_lvl   <= 1'b0;
      exp_pkt <= 1'b0;
      msnap   <= '0;
    end else begin
      if (spec_match(mframe) && !m_lvl) begin
        msnap    <= {mframe, 1'b0};
        snap_cnt <= snap_cnt + 1;
      end
      m_lvl <= spec_match(mframe);
`ifdef PKT_REC_STICKY_EN
      if (spec_match(mframe))
        exp_pkt <= 1'b1;
      else if (wrap_req != wrap_seen)
        exp_pkt <= 1'b0;
      wrap_seen <= wrap_req;
`else
      exp_pkt <= spec_match(mframe);
`endif
      if (sh_en)
        mframe <= {mframe[61:0], din};
    end
  end

  task automatic check1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en)
        check1("pkt_rec_cycle", pkt_rec, exp_pkt);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int mptr      = 0;
  int snap_seen = 0;

  task automatic shift_bit(input logic b);
    din   = b;
    sh_en = 1'b1;
    @(negedge clk);
    sh_en = 1'b0;
    din   = 1'b0;
  endtask

  task automatic shift_frame(input logic [62:0] f, input logic gaps);
    for (int i = 62; i >= 0; i--) begin
      shift_bit(f[i]);
      if (gaps && ($urandom_range(0, 3) == 0))
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  // SPI mode-0 master, SCK period 8 clk; checks the bits seen against the model.
  task automatic spi_xfer(input logic [7:0] mb, input int nb, output logic [7:0] got);
    logic [7:0] expb;
`ifdef PKT_REC_STICKY_EN
    logic wrap;
`endif
    if (snap_cnt != snap_seen) begin
      snap_seen = snap_cnt;
      mptr      = 0;
    end
    expb = 8'(msnap >> (8 * (7 - mptr)));
    got  = '0;
    CS   = 1'b0;
    SCK  = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      MOSI = mb[7-i];
      repeat (4) @(negedge clk);
      got = {got[6:0], MISO};
      SCK = 1'b1;
      repeat (4) @(negedge clk);
      SCK = 1'b0;
    end
    repeat (4) @(negedge clk);
`ifdef PKT_REC_STICKY_EN
    wrap = (nb == 8) && (mb != 8'h5A) && (mptr == 7);
    if (wrap)
      chk_en = 1'b0;
`endif
    CS   = 1'b1;
    MOSI = 1'b0;
    repeat (8) @(negedge clk);
`ifdef PKT_REC_STICKY_EN
    if (wrap) begin
      wrap_req++;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
    end
`endif
    if (nb == 8) begin
      check8("spi_byte", got, expb);
      mptr = (mb == 8'h5A) ? 0 : (mptr + 1) % 8;
    end else begin
      check8("spi_abort_bits", got, expb >> (8 - nb));
    end
  endtask

  logic [62:0] dframe;
  logic [63:0] all_bytes;
  logic [63:0] dsnap;
  logic [7:0]  got;
  logic [7:0]  nomatch_bits;
  logic [62:0] rf;
  logic [7:0]  mb;
  int          nb;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check1("rst_pkt_rec", pkt_rec, 1'b0);
    check1("rst_miso", MISO, 1'b0);
    rst    = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 1'(i);
      @(negedge clk);
    end
    din = 1'b0;

    nomatch_bits = 8'b1010_1100;
    for (int i = 7; i >= 0; i--)
      shift_bit(nomatch_bits[i]);
    @(negedge clk);
    check1("nomatch_pkt_rec", pkt_rec, 1'b0);

    // Directed frame; payload bit 9 is 0 so the frame one shift earlier cannot match.
    dframe = {5'h1F, 21'h1D2C5B, 5'h1F, 23'h36A4C6, 9'h1FF};
    for (int i = 62; i >= 1; i--)
      shift_bit(dframe[i]);
    for (int i = 0; i < 4; i++) begin
      din = 1'(i);
      @(negedge clk);
    end
    shift_bit(dframe[0]);
    check1("match_lat0", pkt_rec, 1'b0);
    @(negedge clk);
    check1("match_lat1", pkt_rec, 1'b1);
    shift_bit(1'b0);
    check1("break_lat0", pkt_rec, 1'b1);
    @(negedge clk);
`ifdef PKT_REC_STICKY_EN
    check1("break_sticky", pkt_rec, 1'b1);
`else
    check1("break_level", pkt_rec, 1'b0);
`endif

    dsnap     = {dframe, 1'b0};
    all_bytes = '0;
    for (int b = 0; b < 8; b++) begin
      spi_xfer(8'hC3, 8, got);
      all_bytes = {all_bytes[55:0], got};
      if (b == 0)
        check8("byte0_literal", got, 8'hFF);
    end
    check64("spi_frame", all_bytes, dsnap);
    check1("pkt_after_read", pkt_rec, 1'b0);

    spi_xfer(8'hC3, 8, got);
    check8("wrap_byte0", got, 8'hFF);
    spi_xfer(8'hC3, 4, got);
    spi_xfer(8'h5A, 8, got);
    check8("abort_keeps_ptr", got, dsnap[55:48]);
    spi_xfer(8'hC3, 8, got);
    check8("rewind_byte0", got, 8'hFF);
    spi_xfer(8'h00, 8, got);
    check8("after_rewind_byte1", got, dsnap[55:48]);

    // Reset in the middle of a transaction.
    CS = 1'b0;
    repeat (8) @(negedge clk);
    SCK = 1'b1;
    repeat (4) @(negedge clk);
    SCK = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check1("midrst_miso", MISO, 1'b0);
    check1("midrst_pkt", pkt_rec, 1'b0);
    rst = 1'b0;
    CS  = 1'b1;
    mptr = 0;
    repeat (4) @(negedge clk);
    check1("postrst_miso", MISO, 1'b0);
    spi_xfer(8'hC3, 8, got);
    check8("postrst_byte", got, 8'h00);

    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(20, 80)) begin
        din   = 1'($urandom_range(0, 1));
        sh_en = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      sh_en = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        rf        = 63'({$urandom, $urandom});
        rf[62:58] = 5'h1F;
        rf[36:32] = 5'h1F;
        rf[8:0]   = 9'h1FF;
        shift_frame(rf, 1'b1);
      end
      repeat (2) @(negedge clk);
      repeat ($urandom_range(3, 10)) begin
        mb = ($urandom_range(0, 5) == 0) ? 8'h5A : 8'($urandom);
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
        spi_xfer(mb, nb, got);
      end
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_packet_spi_top.md
Name: sync_packet_spi_top

Overview:
- Bit-serial frame receiver with an SPI slave read-out port.
- `din` is shifted into a 63-bit frame register on each `sh_en` strobe.
- When three fixed sync fields all read 1, `pkt_rec` asserts and the frame is snapshotted.
- An SPI master then reads the snapshot, one byte per CS transaction, over `MISO`.
- Sits between the slow serial front end and the host-side SPI bus.

Parameters:
- FRAME_LEN, 63, frame shift-register length.
- SCK_SYNC_STAGES, 2, synchronizer depth for CS/SCK/MOSI.
- RST_PTR_CMD, 8'h5A, MOSI byte that rewinds the read pointer.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial frame data.
- sh_en  input  1  shift strobe; one shift per clk edge where it is high.
- CS  input  1  SPI chip select, active low.
- SCK  input  1  SPI clock, mode 0 (idle low, sample on rise).
- MOSI  input  1  SPI master-out data, MSB first.
- MISO  output  1  SPI slave-out data, MSB first.
- pkt_rec  output  1  frame-match flag.

Behaviour:
- Reset (async, rst=1):
  - frame register, snapshot, pointer, SPI shifters and counters cleared.
  - pkt_rec=0, MISO=0.
- Shift: on a posedge clk with sh_en=1, frame <= {frame[61:0], din}. Bit 62 is the oldest bit. sh_en=0 holds the frame.
- Match condition, all of:
  - frame[62:58]==5'b11111
  - frame[36:32]==5'b11111
  - frame[8:0]==9'h1FF
  - Payload bits 57:37 and 31:9 are don't-care.
- pkt_rec is registered: it equals the match of the frame value one clk after the shift that produced it. It is a level, recomputed every cycle.
- Snapshot: on a 0->1 transition of the match, tx_buf[63:0] <= {frame, 1'b0} and byte pointer ptr <= 0. A repeated match while already 1 does not re-snapshot.
- SPI input sync: CS, SCK and MOSI each pass through SCK_SYNC_STAGES flops; edges are detected in the clk domain. SCK high and low phases must each be >= 3 clk periods; faster SCK is unsupported.
- CS falling edge:
  - tx_sh <= tx_buf[63-8*ptr -: 8]; MISO = tx_sh[7].
  - bit counter <= 0, rx_sh <= 0.
- SCK rising edge (CS low): rx_sh <= {rx_sh[6:0], MOSI_sync}; bit counter++.
- SCK falling edge (CS low, bit counter 1..7): tx_sh shifts left; MISO = new tx_sh[7].
- CS rising edge:
  - If the bit counter reached 8: ptr <= ptr+1 (wraps 7->0). If rx_sh==RST_PTR_CMD, ptr <= 0 instead.
  - If fewer than 8 bits were clocked, ptr is unchanged (aborted transaction).
- MISO = 0 whenever CS (synced) is high.
- Snapshot during an active transaction: tx_buf and ptr update immediately; the byte already loaded in tx_sh completes unchanged.
- Simultaneous CS rising edge and snapshot: the snapshot wins and ptr=0.
- Reset mid-transaction aborts everything; after release, MISO=0 until the next CS falling edge.

Optional Feature:
- Macro PKT_REC_STICKY_EN.
- Defined: pkt_rec sets on a match and stays 1 until all 8 bytes of the snapshot have been read (ptr wraps 7->0) or reset.
- Undefined: pkt_rec is the registered level match described above.

Decomposition:
- Package sync_packet_pkg holds:
  - FRAME_LEN, field bounds (SYNC0_HI=62/LO=58, SYNC1_HI=36/LO=32, SYNC2_HI=8/LO=0)
  - BYTE_W=8, NUM_BYTES=8, RST_PTR_CMD default.
- One sub-module, spi_slave_byte: input synchronizers, edge detection, bit counter, tx/rx shifters, and an end-of-byte pulse.
- The top holds the frame register, match logic, snapshot and pointer.

Test Plan:
- Reset: pulse rst with sh_en idle -> pkt_rec=0, MISO=0, and no frame change while sh_en=0.
- No match: shift in 8 bits 1,0,1,0,1,1,0,0 -> pkt_rec stays 0.
- Full match: shift 11111, 21 payload bits, 11111, 23 payload bits, nine 1s -> pkt_rec=1 exactly one clk after the final shift; one more 0 shifted -> pkt_rec=0 (non-sticky build).
- SPI read: after the match, run 8 transactions with MOSI=8'hC3 and SCK period 8 clk -> the 8 received bytes concatenate to {frame,1'b0}, MSB first; ptr wraps to 0.
- Abort and rewind: a 4-bit CS-low burst -> ptr unchanged. A full transaction with MOSI=8'h5A -> the next read returns byte 0 (8'hFF for the test frame above).
- Sticky build (PKT_REC_STICKY_EN): after the match, shift a breaking bit -> pkt_rec stays 1 until the 8th byte's CS rises, then 0.
